// File: rtl/seg7_serial_decoder.sv
// Receiver for the bit-serial 7-segment link: assembles {g..a} frames, decodes to a hex digit,
// flags illegal patterns and re-encodes onto HEX0. Define SEG_PARITY_EN for an 8th even-parity bit.
module seg7_serial_decoder #(
  parameter logic [6:0] BLANK_PAT = 7'b1111111,
  parameter logic [6:0] ERR_PAT   = 7'b0000110
) (
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0
);

`ifdef SEG_PARITY_EN
  localparam int FRAME = 8;
`else
  localparam int FRAME = 7;
`endif
  localparam logic [3:0] FRAME_CNT = 4'(FRAME);

  typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_t;

  logic clk;
  logic rst_n;
  logic sw_bit;
  logic restart;
  logic unused_sw;

  assign clk       = KEY[0];
  assign rst_n     = KEY[1];
  assign sw_bit    = SW[9];
  assign restart   = SW[8];
  assign unused_sw = &{1'b0, SW[7:0]};

  state_t             state_q, state_d;
  logic [FRAME-1:0]   shreg_q, shreg_d;
  logic [3:0]         count_q, count_d;
  logic [3:0]         digit_q, digit_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [6:0]         hex_q, hex_d;
  logic               last_q, last_d;

  logic [FRAME-1:0]   frame_in;
  logic [4:0]         dec;
  logic               parity_ok;

  // Returns {legal, digit}; pattern bit0 is segment a.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0010000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'h0: encode = 7'b1000000;
      4'h1: encode = 7'b1111001;
      4'h2: encode = 7'b0100100;
      4'h3: encode = 7'b0110000;
      4'h4: encode = 7'b0011001;
      4'h5: encode = 7'b0010010;
      4'h6: encode = 7'b0000010;
      4'h7: encode = 7'b1111000;
      4'h8: encode = 7'b0000000;
      4'h9: encode = 7'b0010000;
      4'hA: encode = 7'b0001000;
      4'hB: encode = 7'b0000011;
      4'hC: encode = 7'b1000110;
      4'hD: encode = 7'b0100001;
      4'hE: encode = 7'b0000110;
      default: encode = 7'b0001110;
    endcase
  endfunction

  assign frame_in = {sw_bit, shreg_q[FRAME-1:1]};
  assign dec      = decode(frame_in[6:0]);
`ifdef SEG_PARITY_EN
  assign parity_ok = ~(^frame_in);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    digit_d = digit_q;
    valid_d = valid_q;
    err_d   = err_q;
    hex_d   = hex_q;
    last_d  = sw_bit;
    // A restart, or any edge outside RECV, begins a fresh frame with this bit as segment a.
    if (restart || state_q != RECV) begin
      state_d = RECV;
      shreg_d = {sw_bit, {(FRAME-1){1'b0}}};
      count_d = 4'd1;
    end else begin
      shreg_d = frame_in;
      count_d = count_q + 4'd1;
      if (count_q + 4'd1 == FRAME_CNT) begin
        if (dec[4] && parity_ok) begin
          state_d = DONE;
          digit_d = dec[3:0];
          valid_d = 1'b1;
          err_d   = 1'b0;
          hex_d   = encode(dec[3:0]);
        end else begin
          state_d = ERR;
          valid_d = 1'b0;
          err_d   = 1'b1;
          hex_d   = ERR_PAT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= 4'd0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hex_q   <= BLANK_PAT;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      hex_q   <= hex_d;
      last_q  <= last_d;
    end
  end

  assign LEDR = {last_q, count_q[2:0], err_q, valid_q, digit_q};
  assign HEX0 = hex_q;

endmodule
